fetch_redirect: RTL and testbench

Fetch-side thread scheduler and consumer of the branch unit's resolution FIFO. Holds one PC per hardware thread and round-robin issues fetch requests. It parks a thread when decode reports a control-transfer instruction, then pops the branch unit's head entry with `pc_ack_o` and redirects that thread's PC to the resolved target. It is the reading end of the branch-resolution interface.

---
 rtl/fetch_redirect_pkg.sv | 19 +
 rtl/fetch_redirect_rr_arbiter.sv | 30 +++
 rtl/fetch_redirect.sv | 149 ++++++++++++++
 tb/tb_fetch_redirect.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_pkg.sv
// Shared types and constants for the fetch_redirect thread scheduler.
package fetch_redirect_pkg;

  // Per-thread scheduling state.
  typedef enum logic [1:0] {
    TS_RUN     = 2'd0,  // eligible for fetch
    TS_DEC     = 2'd1,  // one instruction in flight, awaiting decode
    TS_WAIT_BR = 2'd2   // parked until the branch unit resolves its control transfer
  } thread_state_e;

  // Byte distance between sequential instructions.
  localparam int unsigned PC_INC = 4;

  // Thread count implied by a thread-id width.
  function automatic int unsigned num_threads(input int unsigned thread_width);
    return 1 << thread_width;
  endfunction

endpackage

// File: rtl/fetch_redirect_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
// N must equal 2**W so that index arithmetic wraps naturally.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant,
  output logic         any_grant
);

  logic [W-1:0] idx;

  // Scan from farthest to nearest so the requester closest after last_grant wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = N; i >= 1; i--) begin
      idx = last_grant + W'(i);
      if (req[idx]) begin
        grant     = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// Fetch-side thread scheduler: keeps one PC per hardware thread, round-robin
// issues fetches, parks threads on control transfers and redirects them from
// the branch unit's resolution FIFO (popped with pc_ack_o).
// Optional build macro: FETCH_REDIRECT_STATS_EN adds saturating ack counters.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef THREAD_WIDTH
`define THREAD_WIDTH 2
`endif

module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter int              XLEN         = `XLEN,
  parameter int              THREAD_WIDTH = `THREAD_WIDTH,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall_i,
  input  logic                           br_empty_i,
  input  logic                           br_valid_i,
  input  logic                           br_true_i,
  input  logic [THREAD_WIDTH-1:0]        br_thread_id_i,
  input  logic [XLEN-1:0]                br_pc_n_i,
  output logic                           pc_ack_o,
  input  logic                           dec_valid_i,
  input  logic [THREAD_WIDTH-1:0]        dec_thread_id_i,
  input  logic                           dec_is_branch_i,
  output logic                           fetch_valid_o,
  input  logic                           fetch_ready_i,
  output logic [XLEN-1:0]                fetch_pc_o,
  output logic [THREAD_WIDTH-1:0]        fetch_thread_id_o,
  output logic [(1<<THREAD_WIDTH)-1:0]   thread_wait_o
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [31:0]                    stat_taken_o,
  output logic [31:0]                    stat_not_taken_o,
  output logic [31:0]                    stat_spurious_o
`endif
);

  localparam int NUM_THREADS = num_threads(THREAD_WIDTH);

  typedef struct packed {
    thread_state_e   state;
    logic [XLEN-1:0] pc;
  } thread_ctx_t;

  thread_ctx_t             ctx_q [NUM_THREADS];
  thread_ctx_t             ctx_d [NUM_THREADS];
  logic [THREAD_WIDTH-1:0] last_grant_q;
  logic [THREAD_WIDTH-1:0] last_grant_d;
  logic [THREAD_WIDTH-1:0] sel;
  logic [NUM_THREADS-1:0]  run_req;
  logic                    any_run;
  logic                    fetch_fire;
  logic                    br_hit;
  logic                    dec_hit;

  // Per-thread eligibility and parked flags straight from current state.
  always_comb begin
    run_req       = '0;
    thread_wait_o = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      run_req[t]       = (ctx_q[t].state == TS_RUN);
      thread_wait_o[t] = (ctx_q[t].state == TS_WAIT_BR);
    end
  end

  rr_arbiter #(
    .N(NUM_THREADS),
    .W(THREAD_WIDTH)
  ) u_rr_arbiter (
    .req       (run_req),
    .last_grant(last_grant_q),
    .grant     (sel),
    .any_grant (any_run)
  );

  assign fetch_valid_o     = any_run && !stall_i;
  assign fetch_fire        = fetch_valid_o && fetch_ready_i;
  assign fetch_pc_o        = ctx_q[sel].pc;
  assign fetch_thread_id_o = sel;

  // The head is popped whenever resolved; only a parked target thread is redirected.
  assign pc_ack_o = !br_empty_i && br_valid_i && !stall_i && rst;
  assign br_hit   = pc_ack_o && (ctx_q[br_thread_id_i].state == TS_WAIT_BR);
  assign dec_hit  = dec_valid_i && (ctx_q[dec_thread_id_i].state == TS_DEC);

  // Next-state: resolution, decode and fetch each consume a different state,
  // so they can never target the same thread in one cycle.
  always_comb begin
    ctx_d        = ctx_q;
    last_grant_d = last_grant_q;
    if (br_hit) begin
      ctx_d[br_thread_id_i].state = TS_RUN;
      ctx_d[br_thread_id_i].pc    = br_pc_n_i;
    end
    if (dec_hit) begin
      ctx_d[dec_thread_id_i].state = dec_is_branch_i ? TS_WAIT_BR : TS_RUN;
    end
    if (fetch_fire) begin
      ctx_d[sel].state = TS_DEC;
      ctx_d[sel].pc    = ctx_q[sel].pc + XLEN'(PC_INC);
      last_grant_d     = sel;
    end
  end

  // State register; a stall freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the context array is small and architecturally visible, so every entry is reset explicitly.
      for (int t = 0; t < NUM_THREADS; t++) begin
        ctx_q[t].state <= TS_RUN;
        ctx_q[t].pc    <= RESET_PC;
      end
      last_grant_q <= '1;
    end else if (!stall_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ctx_q        <= ctx_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef FETCH_REDIRECT_STATS_EN
  // Saturating classification of every accepted resolution.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_taken_o     <= '0;
      stat_not_taken_o <= '0;
      stat_spurious_o  <= '0;
    end else if (pc_ack_o) begin
      if (!br_hit) begin
        if (stat_spurious_o != '1) stat_spurious_o <= stat_spurious_o + 32'd1;
      end else if (br_true_i) begin
        if (stat_taken_o != '1) stat_taken_o <= stat_taken_o + 32'd1;
      end else begin
        if (stat_not_taken_o != '1) stat_not_taken_o <= stat_not_taken_o + 32'd1;
      end
    end
  end
`else
  logic unused_br_true;
  assign unused_br_true = br_true_i;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// Self-checking bench for fetch_redirect: directed scenarios followed by random
// traffic, with expected outputs queued by the driver and compared by a monitor.
module tb_fetch_redirect;

  localparam int          TW  = 2;
  localparam int          NT  = 4;
  localparam logic [31:0] RPC = 32'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        br_empty_i = 1'b1;
  logic        br_valid_i = 1'b0;
  logic        br_true_i = 1'b0;
  logic [1:0]  br_thread_id_i = '0;
  logic [31:0] br_pc_n_i = '0;
  logic        pc_ack_o;
  logic        dec_valid_i = 1'b0;
  logic [1:0]  dec_thread_id_i = '0;
  logic        dec_is_branch_i = 1'b0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_thread_id_o;
  logic [3:0]  thread_wait_o;
`ifdef FETCH_REDIRECT_STATS_EN
  logic [31:0] stat_taken_o, stat_not_taken_o, stat_spurious_o;
`endif

  always #5 clk = ~clk;

  fetch_redirect #(
    .XLEN(32),
    .THREAD_WIDTH(TW),
    .RESET_PC(RPC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .br_empty_i       (br_empty_i),
    .br_valid_i       (br_valid_i),
    .br_true_i        (br_true_i),
    .br_thread_id_i   (br_thread_id_i),
    .br_pc_n_i        (br_pc_n_i),
    .pc_ack_o         (pc_ack_o),
    .dec_valid_i      (dec_valid_i),
    .dec_thread_id_i  (dec_thread_id_i),
    .dec_is_branch_i  (dec_is_branch_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_ready_i    (fetch_ready_i),
    .fetch_pc_o       (fetch_pc_o),
    .fetch_thread_id_o(fetch_thread_id_o),
    .thread_wait_o    (thread_wait_o)
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    .stat_taken_o     (stat_taken_o),
    .stat_not_taken_o (stat_not_taken_o),
    .stat_spurious_o  (stat_spurious_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: per-thread PC, "fetched, awaiting decode", "parked" flags.
  logic [31:0] m_pc [NT];
  bit          m_fetched [NT];
  bit          m_parked [NT];
  int          m_last;

  // Branch-unit FIFO contents as the bench presents them.
  typedef struct {
    int          tid;
    logic [31:0] tgt;
    bit          taken;
  } br_ent_t;
  br_ent_t bq[$];

  typedef struct {
    bit          chk_fetch;
    bit          fv;
    logic [31:0] pc;
    int          tid;
    bit          ack;
    logic [3:0]  wait_v;
  } exp_t;
  exp_t sb[$];

  exp_t        cur_e;
  bit          cur_stall, cur_ready, cur_dv, cur_dbr;
  int          cur_dtid;
  logic [31:0] next_tgt = 32'h0;

  function automatic int m_sel();
    for (int i = 1; i <= NT; i++) begin
      int idx;
      idx = (m_last + i) % NT;
      if (!m_fetched[idx] && !m_parked[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int t = 0; t < NT; t++) begin
      m_pc[t]      = RPC;
      m_fetched[t] = 1'b0;
      m_parked[t]  = 1'b0;
    end
    m_last = NT - 1;
    bq.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue what the outputs must be.
  task automatic drive(input bit stall, input bit ready, input bit dv, input int dtid,
                       input bit dbr, input bit bv);
    int sel;
    stall_i         = stall;
    fetch_ready_i   = ready;
    dec_valid_i     = dv;
    dec_thread_id_i = 2'(dtid);
    dec_is_branch_i = dbr;
    br_valid_i      = bv;
    br_empty_i      = (bq.size() == 0);
    if (bq.size() > 0) begin
      br_thread_id_i = 2'(bq[0].tid);
      br_pc_n_i      = bq[0].tgt;
      br_true_i      = bq[0].taken;
    end else begin
      br_thread_id_i = '0;
      br_pc_n_i      = '0;
      br_true_i      = 1'b0;
    end
    sel             = m_sel();
    cur_e.chk_fetch = (rst === 1'b1);
    cur_e.fv        = (sel >= 0) && !stall;
    cur_e.tid       = 0;
    cur_e.pc        = '0;
    if (sel >= 0) begin
      cur_e.tid = sel;
      cur_e.pc  = m_pc[sel];
    end
    cur_e.ack = (bq.size() > 0) && bv && !stall && (rst === 1'b1);
    for (int t = 0; t < NT; t++) cur_e.wait_v[t] = m_parked[t];
    cur_stall = stall;
    cur_ready = ready;
    cur_dv    = dv;
    cur_dtid  = dtid;
    cur_dbr   = dbr;
    sb.push_back(cur_e);
  endtask

  // Advance one clock edge and apply the specified state transitions to the model.
  task automatic tick();
    int      sel;
    br_ent_t ent;
    sel = m_sel();
    @(posedge clk);
    if (rst !== 1'b1) begin
      m_reset();
    end else if (!cur_stall) begin
      if (cur_e.ack) begin
        ent = bq.pop_front();
        if (m_parked[ent.tid]) begin
          m_parked[ent.tid] = 1'b0;
          m_pc[ent.tid]     = ent.tgt;
        end
      end
      if (cur_dv && m_fetched[cur_dtid]) begin
        m_fetched[cur_dtid] = 1'b0;
        m_parked[cur_dtid]  = cur_dbr;
        if (cur_dbr) begin
          ent.tid   = cur_dtid;
          ent.tgt   = next_tgt;
          ent.taken = 1'($urandom_range(0, 1));
          bq.push_back(ent);
        end
      end
      if (cur_e.fv && cur_ready) begin
        m_fetched[sel] = 1'b1;
        m_pc[sel]      = m_pc[sel] + 32'd4;
        m_last         = sel;
      end
    end
    #1;
    cyc++;
  endtask

  // Let other threads drain until thread t is granted, then check its fetch PC.
  task automatic fetch_thread(input int t, input logic [31:0] exp_pc);
    int other;
    for (int k = 0; k < 16; k++) begin
      if (m_sel() == t) begin
        drive(0, 1, 0, 0, 0, 0);
        #1;
        check("fetch_thread_id", 32'(fetch_thread_id_o), 32'(t));
        check("fetch_thread_pc", fetch_pc_o, exp_pc);
        tick();
        return;
      end
      other = -1;
      for (int i = 0; i < NT; i++) if (other < 0 && i != t && m_fetched[i]) other = i;
      drive(0, 1, other >= 0, (other >= 0) ? other : 0, 0, 0);
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL fetch_thread_timeout: thread %0d never granted, expected a grant", t);
  endtask

  // Monitor: pop the expectation for the current cycle and compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      bad = (pc_ack_o !== e.ack);
      if (e.chk_fetch) begin
        if (fetch_valid_o !== e.fv) bad = 1'b1;
        if (thread_wait_o !== e.wait_v) bad = 1'b1;
        if (e.fv && (fetch_pc_o !== e.pc || 32'(fetch_thread_id_o) !== 32'(e.tid))) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL cycle_outputs (cycle %0d): ack %b/%b valid %b/%b pc %h/%h tid %0d/%0d wait %b/%b (got/expected)",
                 cyc, pc_ack_o, e.ack, fetch_valid_o, e.fv, fetch_pc_o, e.pc,
                 fetch_thread_id_o, e.tid, thread_wait_o, e.wait_v);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    br_ent_t ent;
    int      dtid;
    int      fetched_cnt;
    m_reset();
    @(posedge clk);
    #1;

    // Reset held for two cycles: ack must stay low.
    rst = 1'b0;
    repeat (2) begin drive(0, 1, 0, 0, 0, 1); tick(); end
    rst = 1'b1;

    // Grants to threads 0..3 at the reset PC, then nothing left to fetch.
    for (int i = 0; i < NT; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      #1;
      check("rr_grant_tid", 32'(fetch_thread_id_o), 32'(i));
      check("rr_grant_pc", fetch_pc_o, RPC);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0);
    #1;
    check("all_in_dec_valid", 32'(fetch_valid_o), 32'd0);
    tick();

    // Thread 1 branch redirected to 0x100.
    next_tgt = 32'h100;
    drive(0, 0, 1, 1, 1, 0); tick();
    drive(0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check("redirect_ack", 32'(pc_ack_o), 32'd1);
    tick();
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0);
    #1;
    check("redirect_tid", 32'(fetch_thread_id_o), 32'd1);
    check("redirect_pc", fetch_pc_o, 32'h100);
    tick();

    // Unresolved head for thread 2 waits, then acks once resolved.
    next_tgt = 32'h2000;
    drive(0, 0, 1, 2, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("unresolved_no_ack", 32'(pc_ack_o), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check("resolved_ack", 32'(pc_ack_o), 32'd1);
    tick();

    // Spurious resolution for thread 3 while it is running.
    drive(0, 0, 1, 3, 0, 0); tick();
    ent.tid = 3; ent.tgt = 32'h444; ent.taken = 1'b1;
    bq.push_back(ent);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check("spurious_ack", 32'(pc_ack_o), 32'd1);
    tick();
`ifdef FETCH_REDIRECT_STATS_EN
    check("stat_spurious", stat_spurious_o, 32'd1);
`endif
    fetch_thread(3, RPC + 32'd4);

    // Stall freezes a resolved head and a fetch; both fire once it drops.
    next_tgt = 32'hFFFF_FFFC;
    drive(0, 0, 1, 1, 1, 0); tick();
    drive(1, 1, 0, 0, 0, 1);
    #1;
    check("stall_ack", 32'(pc_ack_o), 32'd0);
    check("stall_valid", 32'(fetch_valid_o), 32'd0);
    tick();
    drive(0, 1, 0, 0, 0, 1);
    #1;
    check("unstall_ack", 32'(pc_ack_o), 32'd1);
    check("unstall_valid", 32'(fetch_valid_o), 32'd1);
    tick();

    // PC wraps from 0xFFFFFFFC to 0.
    fetch_thread(1, 32'hFFFF_FFFC);
    drive(0, 0, 1, 1, 0, 0); tick();
    fetch_thread(1, 32'h0);

    // Mid-run reset returns every thread to the reset PC, thread 0 first.
    rst = 1'b0;
    drive(0, 1, 0, 0, 0, 1); tick();
    rst = 1'b1;
    drive(0, 1, 0, 0, 0, 0);
    #1;
    check("post_reset_tid", 32'(fetch_thread_id_o), 32'd0);
    check("post_reset_pc", fetch_pc_o, RPC);
    check("post_reset_valid", 32'(fetch_valid_o), 32'd1);
    tick();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      next_tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      if (rst && $urandom_range(0, 99) < 3) begin
        ent.tid = $urandom_range(0, NT - 1); ent.tgt = $urandom & 32'hFFFF_FFFC; ent.taken = 1'b0;
        bq.push_back(ent);
      end
      fetched_cnt = 0;
      for (int t = 0; t < NT; t++) if (m_fetched[t]) fetched_cnt++;
      dtid = $urandom_range(0, NT - 1);
      if (fetched_cnt > 0 && $urandom_range(0, 4) != 0) begin
        while (!m_fetched[dtid]) dtid = (dtid + 1) % NT;
      end
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            dtid, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b1;

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
